// File: rtl/pipe_efm_stage.sv
// Segmented first-order error-feedback accumulator (MASH-1) on a skewed 3-slice word.
// Optional LFSR dither on the lsb carry-in is enabled by defining PIPE_EFM_DITHER_EN.
module pipe_efm_stage #(
  parameter int                   P_SLICE_W = 8,
  parameter logic [P_SLICE_W-1:0] P_RST_VAL = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  input  logic [P_SLICE_W-1:0] i_lsb,
  input  logic [P_SLICE_W-1:0] i_isb,
  input  logic [P_SLICE_W-1:0] i_msb,
  output logic [P_SLICE_W-1:0] o_lsb,
  output logic [P_SLICE_W-1:0] o_isb,
  output logic [P_SLICE_W-1:0] o_msb,
  output logic                 o_carry,
  output logic                 o_valid
);

  function automatic logic [P_SLICE_W:0] slice_add(
    input logic [P_SLICE_W-1:0] a,
    input logic [P_SLICE_W-1:0] b,
    input logic                 cin
  );
    return {1'b0, a} + {1'b0, b} + {{P_SLICE_W{1'b0}}, cin};
  endfunction

  logic [P_SLICE_W-1:0] acc_l_p0, acc_i_p1, acc_m_p2;
  logic                 c_l_p0, c_i_p1;
  logic                 en_p1, en_p2;
  logic                 cin_l;
  logic [P_SLICE_W:0]   sum_l, sum_i, sum_m;

`ifdef PIPE_EFM_DITHER_EN
  logic [14:0] lfsr;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      lfsr <= 15'h0001;
    else if (i_en)
      lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
  end

  assign cin_l = lfsr[0];
`else
  assign cin_l = 1'b0;
`endif

  assign sum_l = slice_add(acc_l_p0, i_lsb, cin_l);
  assign sum_i = slice_add(acc_i_p1, i_isb, c_l_p0);
  assign sum_m = slice_add(acc_m_p2, i_msb, c_i_p1);

  // Stage 0: lsb slice, gated by i_en
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_l_p0 <= P_RST_VAL;
      c_l_p0   <= 1'b0;
      en_p1    <= 1'b0;
    end else begin
      en_p1 <= i_en;
      if (i_en)
        {c_l_p0, acc_l_p0} <= sum_l;
      else
        c_l_p0 <= 1'b0;
    end
  end

  // Stage 1: isb slice, consumes the lsb carry of the same word
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_i_p1 <= P_RST_VAL;
      c_i_p1   <= 1'b0;
      en_p2    <= 1'b0;
    end else begin
      en_p2 <= en_p1;
      if (en_p1)
        {c_i_p1, acc_i_p1} <= sum_i;
      else
        c_i_p1 <= 1'b0;
    end
  end

  // Stage 2: msb slice, carry out of the full word
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_m_p2 <= P_RST_VAL;
      o_carry  <= 1'b0;
      o_valid  <= 1'b0;
    end else begin
      o_valid <= en_p2;
      if (en_p2)
        {o_carry, acc_m_p2} <= sum_m;
      else
        o_carry <= 1'b0;
    end
  end

  assign o_lsb = acc_l_p0;
  assign o_isb = acc_i_p1;
  assign o_msb = acc_m_p2;

endmodule

// File: tb/tb_pipe_efm_stage.sv
// Directed + random bench for pipe_efm_stage against a monolithic 24-bit accumulator model.
// Build with PIPE_EFM_DITHER_EN defined to exercise the dithered variant.
module tb_pipe_efm_stage;
  localparam int W  = 8;
  localparam int NR = 10000;
  localparam int N  = 33 + NR + 3;

  logic         clk = 1'b0;
  logic         i_rst, i_en;
  logic [W-1:0] i_lsb, i_isb, i_msb;
  logic [W-1:0] o_lsb, o_isb, o_msb;
  logic         o_carry, o_valid;

  pipe_efm_stage #(.P_SLICE_W(W), .P_RST_VAL(8'h00)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_en(i_en),
    .i_lsb(i_lsb), .i_isb(i_isb), .i_msb(i_msb),
    .o_lsb(o_lsb), .o_isb(o_isb), .o_msb(o_msb),
    .o_carry(o_carry), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  logic [23:0] w_a [N];
  bit          en_a[N];
  bit          rst_a[N];
  logic [W-1:0] cap_l[N], cap_i[N], cap_m[N];
  logic         cap_c[N], cap_v[N];

  int total = 0;
  int bad   = 0;

  // Monolithic reference: 24-bit accumulator over whole words, with a
  // three-deep history so each output slice can be taken from the word it lags.
  logic [23:0] cur_word;
  logic [23:0] macc;
  logic [14:0] mlfsr;
  logic [23:0] hacc[3];
  logic        hc[3], hen[3];
  bit          mrun = 0;
  int          mk = -1;

  always @(posedge clk) begin
    if (mrun) begin
      logic [24:0] sum;
      logic        c;
      mk = mk + 1;
      if (i_rst) begin
        macc  = 24'h000000;
        mlfsr = 15'h0001;
        for (int j = 0; j < 3; j++) begin
          hacc[j] = macc; hc[j] = 1'b0; hen[j] = 1'b0;
        end
      end else begin
        c = 1'b0;
        if (i_en) begin
`ifdef PIPE_EFM_DITHER_EN
          sum   = {1'b0, macc} + {1'b0, cur_word} + {24'd0, mlfsr[0]};
          mlfsr = {mlfsr[13:0], mlfsr[14] ^ mlfsr[13]};
`else
          sum   = {1'b0, macc} + {1'b0, cur_word};
`endif
          c    = sum[24];
          macc = sum[23:0];
        end
        hacc[2] = hacc[1]; hc[2] = hc[1]; hen[2] = hen[1];
        hacc[1] = hacc[0]; hc[1] = hc[0]; hen[1] = hen[0];
        hacc[0] = macc;    hc[0] = c;     hen[0] = i_en;
      end
    end
  end

  always @(negedge clk) begin
    if (mrun && mk >= 0 && mk < N) begin
      logic [W*3+1:0] act, exp;
      act = {o_lsb, o_isb, o_msb, o_carry, o_valid};
      exp = {hacc[0][7:0], hacc[1][15:8], hacc[2][23:16], hc[2], hen[2]};
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL cycle_model cyc=%0d lsb/isb/msb/c/v act=%h/%h/%h/%b/%b exp=%h/%h/%h/%b/%b",
                 mk, o_lsb, o_isb, o_msb, o_carry, o_valid,
                 exp[25:18], exp[17:10], exp[9:2], exp[1], exp[0]);
      end
      cap_l[mk] = o_lsb; cap_i[mk] = o_isb; cap_m[mk] = o_msb;
      cap_c[mk] = o_carry; cap_v[mk] = o_valid;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] res(input int t);
    return {cap_m[t+2], cap_i[t+1], cap_l[t]};
  endfunction

  initial begin
    // Stimulus table: reset, half-scale, full-scale, ripple, bubble, random, flush.
    for (int k = 0; k < N; k++) begin
      w_a[k] = 24'h0; en_a[k] = 1'b0; rst_a[k] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      rst_a[k] = 1'b1; en_a[k] = 1'b1; w_a[k] = 24'($urandom);
    end
    for (int k = 2; k < 10; k++) begin w_a[k] = 24'h800000; en_a[k] = 1'b1; end
    for (int k = 10; k < 16; k++) begin w_a[k] = 24'hFFFFFF; en_a[k] = 1'b1; end
    rst_a[16] = 1'b1;
    w_a[17] = 24'h0000FF; w_a[18] = 24'h000001;
    for (int k = 17; k < 22; k++) en_a[k] = 1'b1;
    for (int k = 22; k < 33; k++) begin
      w_a[k] = 24'h400000; en_a[k] = (k < 26 || k > 28);
    end
    for (int k = 33; k < 33 + NR; k++) begin
      w_a[k]   = 24'($urandom);
      en_a[k]  = ($urandom_range(0, 3) != 0);
      rst_a[k] = ($urandom_range(0, 999) == 0);
    end

    mrun = 1;
    for (int k = 0; k < N; k++) begin
      i_rst    = rst_a[k];
      i_en     = en_a[k];
      cur_word = w_a[k];
      i_lsb    = w_a[k][7:0];
      i_isb    = (k >= 1) ? w_a[k-1][15:8]  : 8'h00;
      i_msb    = (k >= 2) ? w_a[k-2][23:16] : 8'h00;
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    mrun = 0;

    chk("reset_cyc0", {cap_l[0], cap_i[0], cap_m[0], 6'b0, cap_c[0], cap_v[0]}, 32'h0);
    chk("reset_cyc1", {cap_l[1], cap_i[1], cap_m[1], 6'b0, cap_c[1], cap_v[1]}, 32'h0);
    chk("post_reset_valid", {cap_i[2], cap_m[2], 14'b0, cap_c[2], cap_v[2]}, 32'h0);
`ifndef PIPE_EFM_DITHER_EN
    chk("post_reset_lsb", cap_l[2], 32'h0);
    chk("half_carry_seq", {cap_c[4], cap_c[5], cap_c[6], cap_c[7]}, 32'b0101);
    chk("half_msb_a", cap_m[4], 32'h80);
    chk("half_msb_b", cap_m[5], 32'h00);
    chk("full_res0", {res(10), 7'b0, cap_c[12]}, {24'hFFFFFF, 8'h00});
    chk("full_res1", {res(11), 7'b0, cap_c[13]}, {24'hFFFFFE, 8'h01});
    chk("full_res2", {res(12), 7'b0, cap_c[14]}, {24'hFFFFFD, 8'h01});
    chk("ripple_res0", res(17), 24'h0000FF);
    chk("ripple_res1", res(18), 24'h000100);
    chk("ripple_isb_timing", {cap_l[18], cap_i[18], cap_i[19]}, 24'h000001);
    chk("ripple_no_carry", {cap_c[19], cap_c[20], cap_c[21], cap_c[22]}, 32'h0);
    chk("bubble_wrap_carry", cap_c[27], 32'h1);
    chk("bubble_hold", {res(26), res(28)}, {24'h000100, 24'h000100});
    chk("bubble_no_carry", {cap_c[28], cap_c[29], cap_c[30]}, 32'h0);
    chk("bubble_resume", res(29), 24'h400100);
    chk("bubble_valid", {cap_v[27], cap_v[28], cap_v[29], cap_v[30], cap_v[31]}, 32'b10001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
